// File: rtl/cell_tracker.sv
// Tracks a pixel position as (cell index, offset within cell) across a field of
// equal-width cells; a load starts an iterative seek, then each step advances by one pixel.
module cell_tracker #(
  parameter int CELL_SIZE = 24,
  parameter int NUM_CELLS = 24,
  parameter int ORIGIN    = 0,
  parameter int POS_W     = 10,
  parameter int IDX_W     = 5,
  parameter int OFS_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  input  logic             step,
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] blkid,
  output logic [OFS_W-1:0] offset,
  output logic             in_field,
  output logic             cell_first,
  output logic             overrun,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] SEEK  = 3'd2;
  localparam logic [2:0] TRACK = 3'd3;
  localparam logic [2:0] PAST  = 3'd4;

  localparam logic [POS_W-1:0] ORG      = POS_W'(ORIGIN);
  localparam logic [POS_W-1:0] CS       = POS_W'(CELL_SIZE);
  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(CELL_SIZE - 1);
  localparam logic [IDX_W-1:0] BLK_LAST = IDX_W'(NUM_CELLS - 1);
  localparam logic [IDX_W:0]   IDX_END  = (IDX_W+1)'(NUM_CELLS);

  logic [2:0]       state;
  logic [POS_W-1:0] lead;
  logic [POS_W-1:0] rem;
  logic [IDX_W:0]   idx;

  // Handshake: load and step are single-cycle strobes with no ready. load is
  // always accepted; step is accepted only while busy=0, and a step that
  // arrives while busy is discarded and latched into overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lead     <= '0;
      rem      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      blkid    <= '0;
      offset   <= '0;
      in_field <= 1'b0;
      overrun  <= 1'b0;
    end else if (load) begin
      overrun  <= 1'b0;
      blkid    <= '0;
      offset   <= '0;
      in_field <= 1'b0;
      if (load_pos < ORG) begin
        state <= PRE;
        lead  <= ORG - load_pos;
        busy  <= 1'b0;
        valid <= 1'b1;
      end else begin
        state <= SEEK;
        rem   <= load_pos - ORG;
        idx   <= '0;
        busy  <= 1'b1;
        valid <= 1'b0;
      end
    end else begin
      case (state)
        SEEK: begin
          if (step) overrun <= 1'b1;
          if (idx == IDX_END) begin
            state <= PAST;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else if (rem >= CS) begin
            rem <= rem - CS;
            idx <= idx + (IDX_W+1)'(1);
          end else begin
            state    <= TRACK;
            busy     <= 1'b0;
            valid    <= 1'b1;
            in_field <= 1'b1;
            blkid    <= idx[IDX_W-1:0];
            offset   <= rem[OFS_W-1:0];
          end
        end
        PRE: begin
          if (step) begin
            lead <= lead - POS_W'(1);
            if (lead == POS_W'(1)) begin
              state    <= TRACK;
              in_field <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (step) begin
            if (offset != OFS_LAST) begin
              offset <= offset + OFS_W'(1);
            end else if (blkid == BLK_LAST) begin
              // Stepping off the last pixel of the last cell leaves the field.
              state    <= PAST;
              in_field <= 1'b0;
              blkid    <= '0;
              offset   <= '0;
            end else begin
              offset <= '0;
              blkid  <= blkid + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cell_first = in_field && (offset == '0);
  assign dbg_state  = state;

endmodule

// File: tb/tb_cell_tracker.sv
// Directed bench for cell_tracker: a default-parameter instance and an ORIGIN=16
// instance share stimulus; a negedge monitor checks each expectation on its due cycle.
module tb_cell_tracker;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] SEEK  = 3'd2;
  localparam logic [2:0] TRACK = 3'd3;
  localparam logic [2:0] PAST  = 3'd4;

  logic       clk = 1'b0;
  logic       reset, load, step;
  logic [9:0] load_pos;

  logic       a_busy, a_valid, a_in_field, a_cell_first, a_overrun;
  logic [4:0] a_blkid, a_offset;
  logic [2:0] a_state;
  logic       b_busy, b_valid, b_in_field, b_cell_first, b_overrun;
  logic [4:0] b_blkid, b_offset;
  logic [2:0] b_state;

  cell_tracker u_dut_a (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .step(step),
    .busy(a_busy), .valid(a_valid), .blkid(a_blkid), .offset(a_offset),
    .in_field(a_in_field), .cell_first(a_cell_first), .overrun(a_overrun),
    .dbg_state(a_state)
  );

  cell_tracker #(.ORIGIN(16)) u_dut_b (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .step(step),
    .busy(b_busy), .valid(b_valid), .blkid(b_blkid), .offset(b_offset),
    .in_field(b_in_field), .cell_first(b_cell_first), .overrun(b_overrun),
    .dbg_state(b_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {sel, state, busy, valid, blkid, offset, in_field, cell_first, overrun}
  logic [18:0] exp_q[$];
  int          due_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  string       tname  = "none";

  wire [17:0] obs_a = {a_state, a_busy, a_valid, a_blkid, a_offset, a_in_field, a_cell_first, a_overrun};
  wire [17:0] obs_b = {b_state, b_busy, b_valid, b_blkid, b_offset, b_in_field, b_cell_first, b_overrun};

  always @(negedge clk) begin
    logic [18:0] e;
    logic [17:0] act;
    int          d;
    string       n;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      e   = exp_q.pop_front();
      d   = due_q.pop_front();
      n   = name_q.pop_front();
      act = e[18] ? obs_b : obs_a;
      checks++;
      if (d != cyc) begin
        errors++;
        $display("FAIL %s: expectation due at cycle %0d not checked until cycle %0d", n, d, cyc);
      end else if (act !== e[17:0]) begin
        errors++;
        $display("FAIL %s (dut %s, cycle %0d): actual st=%0d busy=%b valid=%b blk=%0d ofs=%0d inf=%b cf=%b ov=%b, required st=%0d busy=%b valid=%b blk=%0d ofs=%0d inf=%b cf=%b ov=%b",
                 n, e[18] ? "b" : "a", cyc,
                 act[17:15], act[14], act[13], act[12:8], act[7:3], act[2], act[1], act[0],
                 e[17:15], e[14], e[13], e[12:8], e[7:3], e[2], e[1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit sel, input logic [2:0] st, input logic b, input logic v,
                     input logic [4:0] bi, input logic [4:0] of, input logic inf,
                     input logic cf, input logic ov);
    exp_q.push_back({sel, st, b, v, bi, of, inf, cf, ov});
    due_q.push_back(cyc);
    name_q.push_back(tname);
  endtask

  task automatic chk_idle(input bit sel);
    chk(sel, IDLE, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_seek(input bit sel, input logic ov);
    chk(sel, SEEK, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, ov);
  endtask

  task automatic chk_pre(input bit sel);
    chk(sel, PRE, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_track(input bit sel, input logic [4:0] bi, input logic [4:0] of,
                           input logic cf, input logic ov);
    chk(sel, TRACK, 1'b0, 1'b1, bi, of, 1'b1, cf, ov);
  endtask

  task automatic chk_past(input bit sel, input logic ov);
    chk(sel, PAST, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, ov);
  endtask

  task automatic do_load(input logic [9:0] pos);
    load     = 1'b1;
    load_pos = pos;
    tick();
    load     = 1'b0;
  endtask

  task automatic steps(input int n);
    step = 1'b1;
    repeat (n) tick();
    step = 1'b0;
  endtask

  // n cycles of busy are expected, then the tick that ends the seek
  task automatic seek_busy(input bit sel, input int n, input logic ov);
    for (int i = 0; i < n; i++) begin
      chk_seek(sel, ov);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; step = 1'b0; load_pos = '0;
    tick(); tick();
    tname = "reset";
    chk_idle(1'b0); chk_idle(1'b1);
    reset = 1'b0;

    tname = "idle_step";
    steps(2);
    chk_idle(1'b0); chk_idle(1'b1);

    tname = "load100";
    do_load(10'd100);
    seek_busy(1'b0, 5, 1'b0);
    chk_track(1'b0, 5'd4, 5'd4, 1'b0, 1'b0);

    tname = "step_in_cell";
    steps(1);
    chk_track(1'b0, 5'd4, 5'd5, 1'b0, 1'b0);
    steps(18);
    chk_track(1'b0, 5'd4, 5'd23, 1'b0, 1'b0);
    steps(1);
    chk_track(1'b0, 5'd5, 5'd0, 1'b1, 1'b0);

    tname = "hold";
    repeat (3) tick();
    chk_track(1'b0, 5'd5, 5'd0, 1'b1, 1'b0);

    tname = "load575";
    do_load(10'd575);
    seek_busy(1'b0, 24, 1'b0);
    chk_track(1'b0, 5'd23, 5'd23, 1'b0, 1'b0);
    steps(1);
    chk_past(1'b0, 1'b0);
    steps(2);
    chk_past(1'b0, 1'b0);

    tname = "load0";
    do_load(10'd0);
    seek_busy(1'b0, 1, 1'b0);
    chk_track(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);

    tname = "overrun";
    do_load(10'd120);
    chk_seek(1'b0, 1'b0);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_seek(1'b0, 1'b1);
    end
    tick();
    step = 1'b0;
    chk_track(1'b0, 5'd5, 5'd0, 1'b1, 1'b1);
    tick();
    chk_track(1'b0, 5'd5, 5'd0, 1'b1, 1'b1);

    tname = "load_clears_overrun";
    do_load(10'd100);
    chk_seek(1'b0, 1'b0);
    tname = "load_beats_step_in_seek";
    step = 1'b1;
    do_load(10'd48);
    step = 1'b0;
    seek_busy(1'b0, 3, 1'b0);
    chk_track(1'b0, 5'd2, 5'd0, 1'b1, 1'b0);

    tname = "load700";
    do_load(10'd700);
    seek_busy(1'b0, 25, 1'b0);
    chk_past(1'b0, 1'b0);

    tname = "reset_mid_seek";
    do_load(10'd300);
    tick();
    chk_seek(1'b0, 1'b0);
    reset = 1'b1;
    step  = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle(1'b0);
    repeat (3) tick();
    step = 1'b0;
    chk_idle(1'b0);

    tname = "reset_beats_load";
    reset = 1'b1;
    do_load(10'd50);
    reset = 1'b0;
    chk_idle(1'b0); chk_idle(1'b1);

    tname = "pre_lead";
    do_load(10'd10);
    chk_pre(1'b1);
    for (int i = 0; i < 5; i++) begin
      steps(1);
      chk_pre(1'b1);
    end
    steps(1);
    chk_track(1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
    steps(23);
    chk_track(1'b1, 5'd0, 5'd23, 1'b0, 1'b0);
    steps(1);
    chk_track(1'b1, 5'd1, 5'd0, 1'b1, 1'b0);

    tname = "origin_edge";
    do_load(10'd16);
    seek_busy(1'b1, 1, 1'b0);
    chk_track(1'b1, 5'd0, 5'd0, 1'b1, 1'b0);

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
